// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared types and helpers for the stream demultiplexer.
//   sel_width(n) : select width for n channels, never less than 1 bit
//   CNT_WIDTH    : width of the optional handshake / drop counters
//   cnt_t        : counter word type
package stream_demux_pkg;

  localparam int CNT_WIDTH = 16;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // max(1, $clog2(n)); a 2-channel demux still needs one select bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_reg.sv
// stream_reg: one-entry valid/ready holding register for a single channel.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           write load_data this cycle (only asserted when ready)
//   load_data      incoming word
//   ready          register can take a word this cycle (empty or draining)
//   valid, data    output side of the channel
//   out_ready      consumer ready
module stream_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             ready,
  output logic             valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data
);

  // Draining and refilling in the same cycle keeps 1 word/cycle throughput.
  assign ready = !valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// stream_demux: 1-to-NUM_OUTPUTS valid/ready demultiplexer. Each accepted
// word is steered by in_sel into that channel's one-entry register; channels
// stall independently. Words with an out-of-range select are accepted,
// dropped, and flagged on err_sel one cycle later.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_sel/in_data   producer side
//   out_valid/out_ready/out_data  per-channel consumer side (packed 2-D data)
//   err_sel                       one-cycle pulse for a dropped illegal word
// Optional (macro STREAM_DEMUX_COUNT_EN):
//   cnt[k]    handshakes completed on channel k, wraps at 16 bits
//   drop_cnt  err_sel pulses, wraps at 16 bits
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int NUM_OUTPUTS = 4,
  localparam int SEL_WIDTH   = sel_width(NUM_OUTPUTS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SEL_WIDTH-1:0]                in_sel,
  input  logic [WIDTH-1:0]                    in_data,
  output logic [NUM_OUTPUTS-1:0]              out_valid,
  input  logic [NUM_OUTPUTS-1:0]              out_ready,
  output logic [NUM_OUTPUTS-1:0][WIDTH-1:0]   out_data,
  output logic                                err_sel
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output cnt_t [NUM_OUTPUTS-1:0]              cnt,
  output cnt_t                                drop_cnt
`endif
);

  logic [NUM_OUTPUTS-1:0] hit;
  logic [NUM_OUTPUTS-1:0] ch_ready;
  logic [NUM_OUTPUTS-1:0] load;
  logic                   legal;

  // One extra bit so NUM_OUTPUTS == 2**SEL_WIDTH still compares correctly.
  assign legal = ({1'b0, in_sel} < (SEL_WIDTH+1)'(NUM_OUTPUTS));

  // Only the addressed channel gates the producer; illegal selects are sunk.
  assign in_ready = legal ? |(hit & ch_ready) : 1'b1;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_ch
    assign hit[k]  = (in_sel == SEL_WIDTH'(k));
    assign load[k] = in_valid && hit[k] && ch_ready[k];

    stream_reg #(.WIDTH(WIDTH)) u_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (ch_ready[k]),
      .valid     (out_valid[k]),
      .out_ready (out_ready[k]),
      .data      (out_data[k])
    );
  end

  // Illegal words are always accepted, so in_valid alone marks the drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_sel <= 1'b0;
    else     err_sel <= in_valid && !legal;
  end

`ifdef STREAM_DEMUX_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_OUTPUTS; k++)
        if (out_valid[k] && out_ready[k]) cnt[k] <= cnt[k] + cnt_t'(1);
      if (err_sel) drop_cnt <= drop_cnt + cnt_t'(1);
    end
  end
`endif

endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: self-checking bench for stream_demux. A 4-channel instance
// takes the directed sequences; a 3-channel instance (so in_sel = 3 is
// illegal) takes the illegal-select case and a randomized run against a
// queue-based reference model. Counter checks apply with STREAM_DEMUX_COUNT_EN.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-channel instance
  logic            in_valid, in_ready, err_sel;
  logic [1:0]      in_sel;
  logic [7:0]      in_data;
  logic [3:0]      out_valid, out_ready;
  logic [3:0][7:0] out_data;
  // 3-channel instance
  logic            v3, r3, e3;
  logic [1:0]      s3;
  logic [7:0]      d3;
  logic [2:0]      ov3, or3;
  logic [2:0][7:0] od3;
`ifdef STREAM_DEMUX_COUNT_EN
  cnt_t [3:0] cnt;
  cnt_t       drop_cnt;
  cnt_t [2:0] cnt3;
  cnt_t       drop3;
`endif

  stream_demux #(.WIDTH(8), .NUM_OUTPUTS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err_sel(err_sel)
`ifdef STREAM_DEMUX_COUNT_EN
    , .cnt(cnt), .drop_cnt(drop_cnt)
`endif
  );

  stream_demux #(.WIDTH(8), .NUM_OUTPUTS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(r3),
    .in_sel(s3), .in_data(d3), .out_valid(ov3),
    .out_ready(or3), .out_data(od3), .err_sel(e3)
`ifdef STREAM_DEMUX_COUNT_EN
    , .cnt(cnt3), .drop_cnt(drop3)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
    logic [3:0] exp_valid;
  } steer_t;

  // reference model state for the 3-channel random run
  logic [7:0] mq [3][$];
  int         mcnt [3];
  int         mdrop;
  logic       exp_err;

  initial begin
    steer_t tbl [4];
    logic   hold, legal, exp_rdy;

    tbl[0] = '{2'd0, 8'h11, 4'b0001};
    tbl[1] = '{2'd1, 8'h22, 4'b0010};
    tbl[2] = '{2'd2, 8'h33, 4'b0100};
    tbl[3] = '{2'd3, 8'h44, 4'b1000};

    rst = 1'b1;
    in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    v3 = 1'b0; s3 = '0; d3 = '0; or3 = '0;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_err_sel", 32'(err_sel), 32'h0);
    tick();
    rst = 1'b0;

    // reset mid-stream: word in channel 2 is discarded asynchronously
    tick();
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5; out_ready = 4'h0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_loaded_valid", 32'(out_valid), 32'h4);
    chk("midrst_loaded_data", 32'(out_data[2]), 32'hA5);
    #1 rst = 1'b1;
    #1;
    chk("midrst_async_valid", 32'(out_valid), 32'h0);
    chk("midrst_async_data", 32'(out_data), 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'h1);

    // directed steering from the table
    tick();
    out_ready = 4'hF;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sel = tbl[i].sel; in_data = tbl[i].data;
      @(negedge clk);
      chk("steer_in_ready", 32'(in_ready), 32'h1);
      chk("steer_idle_before", 32'(out_valid), 32'h0);
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      chk("steer_valid", 32'(out_valid), 32'(tbl[i].exp_valid));
      chk("steer_data", 32'(out_data[tbl[i].sel]), 32'(tbl[i].data));
      tick();
    end
    @(negedge clk);
    chk("steer_no_dup", 32'(out_valid), 32'h0);

    // backpressure isolation on channel 1
    tick();
    out_ready = 4'b1101;
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h10;
    @(negedge clk);
    chk("bp_first_ready", 32'(in_ready), 32'h1);
    tick();
    in_data = 8'h20;
    @(negedge clk);
    chk("bp_second_stalled", 32'(in_ready), 32'h0);
    chk("bp_hold_data", 32'(out_data[1]), 32'h10);
    tick();
    @(negedge clk);
    chk("bp_still_stalled", 32'(in_ready), 32'h0);
    chk("bp_hold_data2", 32'(out_data[1]), 32'h10);
    tick();
    in_sel = 2'd3; in_data = 8'h30;
    @(negedge clk);
    chk("bp_ch3_not_blocked", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_ch3_valid", 32'(out_valid), 32'b1010);
    chk("bp_ch3_data", 32'(out_data[3]), 32'h30);
    chk("bp_ch1_held", 32'(out_data[1]), 32'h10);
    tick();
    in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h20; out_ready = 4'hF;
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'h1);
    chk("bp_release_first", 32'(out_data[1]), 32'h10);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'b0010);
    chk("bp_second_data", 32'(out_data[1]), 32'h20);
    tick();
    @(negedge clk);
    chk("bp_drained", 32'(out_valid), 32'h0);

    // full throughput on channel 0
    tick();
    in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in_data = 8'(i);
      @(negedge clk);
      chk("tp_in_ready", 32'(in_ready), 32'h1);
      if (i > 0) begin
        chk("tp_valid", 32'(out_valid), 32'h1);
        chk("tp_data", 32'(out_data[0]), 32'(i - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("tp_last_data", 32'(out_data[0]), 32'h0F);
    chk("tp_last_valid", 32'(out_valid), 32'h1);
    tick();
    @(negedge clk);
    chk("tp_drained", 32'(out_valid), 32'h0);

    // illegal select on the 3-channel instance
    tick();
    v3 = 1'b1; s3 = 2'd3; d3 = 8'hEE; or3 = 3'b111;
    @(negedge clk);
    chk("ill_in_ready", 32'(r3), 32'h1);
    chk("ill_err_before", 32'(e3), 32'h0);
    tick();
    v3 = 1'b0;
    @(negedge clk);
    chk("ill_err_pulse", 32'(e3), 32'h1);
    chk("ill_no_valid", 32'(ov3), 32'h0);
`ifdef STREAM_DEMUX_COUNT_EN
    tick();
    @(negedge clk);
    chk("ill_drop_cnt", 32'(drop3), 32'h1);
`else
    tick();
    @(negedge clk);
`endif
    chk("ill_err_cleared", 32'(e3), 32'h0);

    // randomized run against the queue model
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin mq[k].delete(); mcnt[k] = 0; end
    mdrop = 0; exp_err = 1'b0; hold = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        v3 = ($urandom_range(0, 3) != 0);
        s3 = 2'($urandom_range(0, 3));
        d3 = 8'($urandom);
      end
      or3 = 3'($urandom);
      @(negedge clk);
      legal   = (s3 < 2'd3);
      exp_rdy = legal ? (mq[s3].size() == 0 || or3[s3]) : 1'b1;
      chk("rnd_in_ready", 32'(r3), 32'(exp_rdy));
      chk("rnd_err_sel", 32'(e3), 32'(exp_err));
      for (int k = 0; k < 3; k++) begin
        chk("rnd_out_valid", 32'(ov3[k]), 32'(mq[k].size() != 0));
        if (mq[k].size() != 0) chk("rnd_out_data", 32'(od3[k]), 32'(mq[k][0]));
      end
      for (int k = 0; k < 3; k++)
        if (mq[k].size() != 0 && or3[k]) begin
          void'(mq[k].pop_front());
          mcnt[k]++;
        end
      exp_err = v3 && !legal;
      if (exp_err) mdrop++;
      if (v3 && legal && exp_rdy) mq[s3].push_back(d3);
      hold = v3 && !exp_rdy;
      tick();
    end
    v3 = 1'b0;
`ifdef STREAM_DEMUX_COUNT_EN
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("rnd_cnt", 32'(cnt3[k]), 32'(mcnt[k] % 65536));
    chk("rnd_drop_cnt", 32'(drop3), 32'(mdrop % 65536));

    // counter wrap: 65537 handshakes on channel 0
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0; out_ready = 4'hF; in_data = 8'h5A;
    repeat (65537) @(posedge clk);
    #1 in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("wrap_cnt0", 32'(cnt[0]), 32'h1);
    for (int k = 1; k < 4; k++) chk("wrap_cnt_other", 32'(cnt[k]), 32'h0);
    chk("wrap_drop_cnt", 32'(drop_cnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-NUM_OUTPUTS demultiplexer for valid/ready streams; the inverse of the 2:1 mux datapath.
- Each accepted input word is steered to the output channel named by in_sel, through a one-entry register per channel.
- Sits between a single producer and several independent consumers. Each channel stalls independently.

Parameters:
- WIDTH, 8, data width in bits.
- NUM_OUTPUTS, 4, number of output channels; legal range 2..16.
- SEL_WIDTH, derived = max(1, $clog2(NUM_OUTPUTS)), select width; not user-overridable.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word accepted this cycle when in_valid && in_ready.
- in_sel  input  SEL_WIDTH  destination channel; sampled with in_data.
- in_data  input  WIDTH  payload.
- out_valid  output  NUM_OUTPUTS  per-channel valid.
- out_ready  input  NUM_OUTPUTS  per-channel consumer ready.
- out_data  output  [NUM_OUTPUTS-1:0][WIDTH-1:0]  per-channel payload, packed 2-D.
- err_sel  output  1  one-cycle pulse: an accepted word had in_sel >= NUM_OUTPUTS and was dropped.

Behaviour:
- Reset (async assert, sync release): out_valid = 0, out_data = 0, err_sel = 0. Any word held in a channel register is discarded.
- Channel register k:
  - Loads in_data when a transfer is accepted with in_sel == k.
  - out_valid[k] rises the following cycle; latency is exactly 1 cycle.
  - Holds out_data[k] stable while out_valid[k] && !out_ready[k].
  - out_valid[k] clears on the handshake unless a new word for k loads in the same cycle. In that case it stays 1 and the data is replaced, giving back-to-back throughput of 1 word/cycle per channel.
- in_ready is combinational:
  - in_ready = !out_valid[in_sel] || out_ready[in_sel] for a legal in_sel.
  - in_ready = 1 for an illegal in_sel (the word is sunk).
  - in_ready depends only on in_sel, out_valid and out_ready, never on in_valid.
- Illegal select: accepted and dropped. err_sel = 1 the next cycle for 1 cycle. No channel is modified.
- Simultaneous events: a channel draining while another channel loads are independent. Only the selected channel's state gates in_ready. A full, stalled channel does not block traffic to other channels.
- Ordering: per-channel order is preserved. No ordering guarantee across channels.
- Producer rule: in_data and in_sel must hold stable while in_valid && !in_ready. The block does not check this.
- No data is ever duplicated; each accepted word appears on at most one channel exactly once.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN.
- Defined:
  - Adds output cnt, type [NUM_OUTPUTS-1:0][15:0]. cnt[k] increments on each out_valid[k] && out_ready[k] handshake.
  - The counter wraps 0xFFFF -> 0x0000 and resets to 0.
  - Adds output drop_cnt [15:0], which increments on each err_sel pulse and also wraps.
- Undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package stream_demux_pkg:
  - function sel_width(int n) returning max(1, $clog2(n)).
  - localparam CNT_WIDTH = 16.
  - typedef cnt_t.
- Sub-module stream_reg: one-entry valid/ready register with load, data, valid and ready. Instantiated NUM_OUTPUTS times via generate.

Test Plan:
- Reset mid-stream: load channel 2 with 0xA5, assert rst before drain -> out_valid = 0000, out_data all 0 immediately (asynchronous). After release, in_ready = 1.
- Directed steering: send 0x11/sel 0, 0x22/sel 1, 0x33/sel 2, 0x44/sel 3, all out_ready = 1 -> each word appears on its channel exactly 1 cycle after acceptance, once, and no other out_valid rises.
- Backpressure isolation: out_ready[1] = 0, send 0x10/sel 1 then 0x20/sel 1 then 0x30/sel 3 ->
  - in_ready = 0 on the second word;
  - out_data[1] holds 0x10 stable;
  - the sel 3 word is not blocked while the sel 1 word is held, so 0x30 delivers on channel 3 one cycle after it is offered;
  - raising out_ready[1] releases 0x10 then 0x20 in order.
- Full-throughput: channel 0 streams 0x00..0x0F with out_ready[0] = 1 continuously -> in_ready = 1 every cycle, 16 words in 17 cycles, order preserved.
- Illegal select (NUM_OUTPUTS = 3, in_sel = 3, data 0xEE) -> in_ready = 1, err_sel pulses 1 cycle, no out_valid change. With STREAM_DEMUX_COUNT_EN: drop_cnt = 1.
- Counter wrap (STREAM_DEMUX_COUNT_EN): drive 65537 handshakes on channel 0 -> cnt[0] = 1, other counters 0.
